// File: rtl/nn_link_responder.sv
// rtl/nn_link_responder.sv - perceptron serial-link packet responder; NN_LINK_TIMEOUT_EN adds an inter-byte payload timeout
module nn_link_responder #(
    parameter logic [7:0] OP_READ               = 8'd5,
    parameter logic [7:0] OP_WRITE_WEIGHTS      = 8'd50,
    parameter logic [7:0] OP_WRITE_INPUTS       = 8'd51,
    parameter logic [7:0] OP_READ_RESPONSE      = 8'd100,
    parameter logic [7:0] OP_WRITE_RESPONSE_OK  = 8'd101,
    parameter logic [7:0] OP_WRITE_RESPONSE_ERR = 8'd102,
    parameter int         TIMEOUT_CYCLES        = 120000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic [15:0] result,
    output logic [15:0] weight1,
    output logic [15:0] weight2,
    output logic [15:0] input1,
    output logic [15:0] input2,
    output logic        load_weights,
    output logic        load_inputs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_PAYLOAD,
        S_COMMIT,
        S_TX_LOAD,
        S_TX_REQ,
        S_TX_WAIT
    } state_t;

    state_t      state;
    logic [7:0]  shadow [0:7];
    logic [2:0]  tx_len;
    logic [2:0]  tx_idx;
    logic [2:0]  pay_cnt;
    logic [23:0] pay;
    logic        tgt_weights;

`ifdef NN_LINK_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            tx_len       <= '0;
            tx_idx       <= '0;
            pay_cnt      <= '0;
            pay          <= '0;
            tgt_weights  <= 1'b0;
            weight1      <= '0;
            weight2      <= '0;
            input1       <= '0;
            input2       <= '0;
            load_weights <= 1'b0;
            load_inputs  <= 1'b0;
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
`ifdef NN_LINK_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            load_weights <= 1'b0;
            load_inputs  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        tx_idx  <= '0;
                        pay_cnt <= '0;
                        if (rx_data == OP_READ) begin
                            // Snapshot in the opcode cycle keeps all 7 bytes coherent.
                            shadow[0] <= OP_READ_RESPONSE;
                            shadow[1] <= weight1[15:8];
                            shadow[2] <= weight1[7:0];
                            shadow[3] <= weight2[15:8];
                            shadow[4] <= weight2[7:0];
                            shadow[5] <= result[15:8];
                            shadow[6] <= result[7:0];
                            tx_len    <= 3'd7;
                            state     <= S_TX_LOAD;
                        end else if (rx_data == OP_WRITE_WEIGHTS || rx_data == OP_WRITE_INPUTS) begin
                            tgt_weights <= (rx_data == OP_WRITE_WEIGHTS);
                            state       <= S_RX_PAYLOAD;
`ifdef NN_LINK_TIMEOUT_EN
                            to_cnt      <= '0;
`endif
                        end else begin
                            shadow[0] <= OP_WRITE_RESPONSE_ERR;
                            tx_len    <= 3'd1;
                            state     <= S_TX_LOAD;
                        end
                    end
                end
                S_RX_PAYLOAD: begin
`ifdef NN_LINK_TIMEOUT_EN
                    to_cnt <= to_cnt + TW'(1);
`endif
                    if (rx_error) begin
                        shadow[0] <= OP_WRITE_RESPONSE_ERR;
                        tx_len    <= 3'd1;
                        state     <= S_TX_LOAD;
                    end else if (rx_valid) begin
`ifdef NN_LINK_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                        pay_cnt <= pay_cnt + 3'd1;
                        pay     <= {pay[15:0], rx_data};
                        // Fourth byte comes straight from rx_data so the write lands in the COMMIT cycle.
                        if (pay_cnt == 3'd3) begin
                            state <= S_COMMIT;
                            if (tgt_weights) begin
                                weight1      <= pay[23:8];
                                weight2      <= {pay[7:0], rx_data};
                                load_weights <= 1'b1;
                            end else begin
                                input1      <= pay[23:8];
                                input2      <= {pay[7:0], rx_data};
                                load_inputs <= 1'b1;
                            end
                        end
                    end
`ifdef NN_LINK_TIMEOUT_EN
                    else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        shadow[0] <= OP_WRITE_RESPONSE_ERR;
                        tx_len    <= 3'd1;
                        state     <= S_TX_LOAD;
                    end
`endif
                end
                S_COMMIT: begin
                    shadow[0] <= OP_WRITE_RESPONSE_OK;
                    tx_len    <= 3'd1;
                    state     <= S_TX_LOAD;
                end
                S_TX_LOAD: begin
                    tx_data  <= shadow[tx_idx];
                    tx_start <= 1'b1;
                    state    <= S_TX_REQ;
                end
                S_TX_REQ: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (!tx_busy) begin
                        tx_idx <= tx_idx + 3'd1;
                        state  <= (tx_idx + 3'd1 == tx_len) ? S_IDLE : S_TX_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_link_responder.sv
// tb/tb_nn_link_responder.sv - randomized self-checking bench for nn_link_responder
module tb_nn_link_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_error;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [15:0] result;
    logic [15:0] weight1, weight2, input1, input2;
    logic        load_weights, load_inputs;

    int n_cmp = 0;
    int n_err = 0;
    byte unsigned cap_q[$];
    int gap_q[$];
    int lw_cnt = 0;
    int li_cnt = 0;
    logic [15:0] m_w1 = '0, m_w2 = '0, m_i1 = '0, m_i2 = '0;

    nn_link_responder #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .result(result),
        .weight1(weight1), .weight2(weight2), .input1(input1), .input2(input2),
        .load_weights(load_weights), .load_inputs(load_inputs)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART transmitter: accepts a byte on tx_start, stays busy a random time.
    initial begin : uart_model
        int gap;
        gap = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            gap++;
            if (tx_start && !tx_busy) begin
                cap_q.push_back(tx_data);
                gap_q.push_back(gap);
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                tx_busy = 1'b0;
                gap = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (load_weights) lw_cnt++;
        if (load_inputs) li_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic err);
        rx_data = b; rx_valid = 1'b1; rx_error = err;
        @(negedge clk);
        rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic expect_resp(input string tag, input byte unsigned exp[$]);
        int t;
        t = 0;
        while (cap_q.size() < exp.size() && t < 20000) begin @(negedge clk); t++; end
        check_eq({tag, "_len"}, cap_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), cap_q[i], exp[i]);
            if (i > 0) check_eq($sformatf("%s_gap%0d", tag, i), gap_q[i], 2);
        end
        t = 0;
        while (tx_busy && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check_eq({tag, "_no_extra"}, cap_q.size(), exp.size());
        cap_q.delete();
        gap_q.delete();
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_w1"}, weight1, m_w1);
        check_eq({tag, "_w2"}, weight2, m_w2);
        check_eq({tag, "_i1"}, input1, m_i1);
        check_eq({tag, "_i2"}, input2, m_i2);
    endtask

    task automatic do_read(input logic [15:0] r);
        int s0;
        byte unsigned exp[$];
        s0 = lw_cnt + li_cnt;
        result = r;
        send_byte(8'd5, 1'b0);
        check_eq("rd_lat0", tx_start, 1'b0);
        result = 16'($urandom);
        @(negedge clk);
        check_eq("rd_lat1", tx_start, 1'b1);
        exp.push_back(8'd100);
        exp.push_back(m_w1[15:8]); exp.push_back(m_w1[7:0]);
        exp.push_back(m_w2[15:8]); exp.push_back(m_w2[7:0]);
        exp.push_back(r[15:8]);    exp.push_back(r[7:0]);
        expect_resp("read", exp);
        check_eq("rd_no_strobe", lw_cnt + li_cnt, s0);
    endtask

    task automatic do_write(input logic is_w, input logic [31:0] pl);
        int lw0, li0;
        byte unsigned exp[$];
        lw0 = lw_cnt; li0 = li_cnt;
        send_byte(is_w ? 8'd50 : 8'd51, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(pl[31-8*i -: 8], 1'b0);
        end
        if (is_w) begin m_w1 = pl[31:16]; m_w2 = pl[15:0]; end
        else begin m_i1 = pl[31:16]; m_i2 = pl[15:0]; end
        check_eq("wr_strobe_w", load_weights, is_w);
        check_eq("wr_strobe_i", load_inputs, !is_w);
        check_regs("wr_commit");
        @(negedge clk);
        check_eq("wr_lat1", tx_start, 1'b0);
        @(negedge clk);
        check_eq("wr_lat2", tx_start, 1'b1);
        exp.push_back(8'd101);
        expect_resp("write", exp);
        check_eq("wr_lw_cnt", lw_cnt - lw0, is_w ? 1 : 0);
        check_eq("wr_li_cnt", li_cnt - li0, is_w ? 0 : 1);
    endtask

    task automatic do_bad_op(input logic [7:0] b);
        int s0;
        byte unsigned exp[$];
        s0 = lw_cnt + li_cnt;
        send_byte(b, 1'b0);
        @(negedge clk);
        check_eq("bad_lat", tx_start, 1'b1);
        exp.push_back(8'd102);
        expect_resp("bad_op", exp);
        check_eq("bad_no_strobe", lw_cnt + li_cnt, s0);
        check_regs("bad_regs");
    endtask

    task automatic do_abort(input logic is_w, input int k, input logic with_valid);
        int s0;
        byte unsigned exp[$];
        s0 = lw_cnt + li_cnt;
        send_byte(is_w ? 8'd50 : 8'd51, 1'b0);
        for (int i = 0; i < k; i++) send_byte(8'($urandom), 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (with_valid) send_byte(8'($urandom), 1'b1);
        else begin rx_error = 1'b1; @(negedge clk); rx_error = 1'b0; end
        exp.push_back(8'd102);
        expect_resp("abort", exp);
        check_eq("abort_no_strobe", lw_cnt + li_cnt, s0);
        check_regs("abort_regs");
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin : main
        int t;
        logic [7:0] b;
        rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_data = '0; result = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_strobes", {load_weights, load_inputs}, 2'b00);
        check_regs("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_read(16'h0001);
        do_write(1'b1, 32'h15AAFC33);
        do_read(16'($urandom));
        do_write(1'b0, 32'hE000200F);
        do_bad_op(8'd7);
        do_read(16'($urandom));

        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("idle_err_silent", cap_q.size(), 0);
        do_read(16'($urandom));

`ifdef NN_LINK_TIMEOUT_EN
        begin
            byte unsigned exp[$];
            int s0;
            s0 = lw_cnt + li_cnt;
            send_byte(8'd50, 1'b0);
            send_byte(8'h11, 1'b0);
            t = 0;
            while (!tx_start && t < 3000) begin @(negedge clk); t++; end
            check_eq("timeout_lat", t, 1001);
            exp.push_back(8'd102);
            expect_resp("timeout", exp);
            check_eq("timeout_no_strobe", lw_cnt + li_cnt, s0);
            check_regs("timeout_regs");
        end
`endif
        do_abort(1'b1, 1, 1'b0);
        do_abort(1'b1, 3, 1'b1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: do_read(16'($urandom));
                1: do_write(1'b1, $urandom);
                2: do_write(1'b0, $urandom);
                3: begin
                    do b = 8'($urandom); while (b == 8'd5 || b == 8'd50 || b == 8'd51);
                    do_bad_op(b);
                end
                default: do_abort(1'($urandom), $urandom_range(0, 3), 1'($urandom));
            endcase
        end

        do_write(1'b1, 32'hA5A55A5A);
        do_write(1'b0, 32'h12345678);
        result = 16'hBEEF;
        send_byte(8'd5, 1'b0);
        t = 0;
        while (cap_q.size() < 3 && t < 2000) begin @(negedge clk); t++; end
        check_eq("mid_read_progress", cap_q.size() >= 3, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        m_w1 = '0; m_w2 = '0; m_i1 = '0; m_i2 = '0;
        check_eq("mid_rst_tx_start", tx_start, 1'b0);
        check_eq("mid_rst_strobes", {load_weights, load_inputs}, 2'b00);
        check_regs("mid_rst");
        rst = 1'b0;
        t = 0;
        while (tx_busy && t < 100) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        cap_q.delete();
        gap_q.delete();
        do_read(16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
